// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and stage-control outputs between pipeline and controller.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  idex_mem_read;
  logic [REG_ADDR_W-1:0] idex_rt;
  logic                  exmem_branch;
  logic                  exmem_zero;
  logic                  dmem_req;
  logic                  dmem_ready;

  logic                  en_pc;
  logic                  en_ifid;
  logic                  en_idex;
  logic                  en_exmem;
  logic                  en_memwb;
  logic                  flush_ifid;
  logic                  flush_idex;
  logic                  flush_exmem;
  logic                  flush_memwb;
  logic                  pc_sel_branch;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
  logic [CNT_W-1:0]      wait_cnt_total;

  modport master (
    output id_rs, id_rt, idex_mem_read, idex_rt, exmem_branch, exmem_zero, dmem_req, dmem_ready,
    input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
    input  flush_ifid, flush_idex, flush_exmem, flush_memwb,
    input  pc_sel_branch, mem_timeout, stall_cnt, flush_cnt, wait_cnt_total
  );

  modport slave (
    input  id_rs, id_rt, idex_mem_read, idex_rt, exmem_branch, exmem_zero, dmem_req, dmem_ready,
    output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
    output flush_ifid, flush_idex, flush_exmem, flush_memwb,
    output pc_sel_branch, mem_timeout, stall_cnt, flush_cnt, wait_cnt_total
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating event counter, cleared by synchronous reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline with dmem watchdog.
// Perf counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise the count ports read 0.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT   = 16,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic                mem_freeze;
  logic                branch_taken;
  logic                load_use;
  // en = {pc, ifid, idex, exmem, memwb}; flush = {ifid, idex, exmem, memwb}
  logic [4:0]          en;
  logic [3:0]          flush;
  logic                pc_sel;

  assign mem_freeze   = bus.dmem_req & ~bus.dmem_ready;
  assign branch_taken = bus.exmem_branch & bus.exmem_zero;
  assign load_use     = bus.idex_mem_read
                      & (bus.idex_rt != REG_ADDR_W'(REG_ZERO))
                      & ((bus.idex_rt == bus.id_rs) | (bus.idex_rt == bus.id_rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    en         = '0;
    flush      = '0;
    pc_sel     = 1'b0;
    if (rst) begin
      flush = 4'b1111;
    end else if (state_q == ERR) begin
      en    = '0;
    end else if (mem_freeze) begin
      // Hold the front of the pipe and let a bubble drain into WB.
      en    = 5'b00001;
      flush = 4'b0001;
      if ((state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST)) begin
        state_d = ERR;
      end else begin
        state_d    = MEM_WAIT;
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      en         = 5'b11111;
      if (branch_taken) begin
        flush  = 4'b1110;
        pc_sel = 1'b1;
      end else if (load_use) begin
        en    = 5'b00111;
        flush = 4'b0100;
      end
    end
  end

  assign {bus.en_pc, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb} = en;
  assign {bus.flush_ifid, bus.flush_idex, bus.flush_exmem, bus.flush_memwb} = flush;
  assign bus.pc_sel_branch = pc_sel;
  assign bus.mem_timeout   = (state_q == ERR) & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_total;

  // Events are recovered from the decoded controls so each matches exactly one priority branch.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush == 4'b0100),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pc_sel),
    .cnt_o (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i ((flush == 4'b0001) && (en == 5'b00001)),
    .cnt_o (wait_total)
  );

  assign bus.stall_cnt      = stall_cnt;
  assign bus.flush_cnt      = flush_cnt;
  assign bus.wait_cnt_total = wait_total;
`else
  assign bus.stall_cnt      = {CNT_W{1'b0}};
  assign bus.flush_cnt      = {CNT_W{1'b0}};
  assign bus.wait_cnt_total = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized self-checking bench for pipe_hazard_ctrl against a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int MAX_WAIT = 16;
  localparam int CW       = 4;
  localparam int CMAX     = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: count of consecutive wait cycles, sticky error, event tallies.
  int m_waited = 0;
  bit m_err    = 0;
  int m_stall  = 0;
  int m_flush  = 0;
  int m_wtot   = 0;

  function automatic bit hazard_hit();
    return bus.idex_mem_read && (bus.idex_rt != 0) &&
           ((bus.idex_rt == bus.id_rs) || (bus.idex_rt == bus.id_rt));
  endfunction

  // {en_pc,en_ifid,en_idex,en_exmem,en_memwb, flush_ifid,flush_idex,flush_exmem,flush_memwb, pc_sel, timeout}
  function automatic logic [10:0] model_out();
    logic [4:0] en;
    logic [3:0] fl;
    logic       pc;
    logic       to;
    en = 5'b11111; fl = 4'b0000; pc = 1'b0; to = 1'b0;
    if (rst) begin
      en = 5'b00000; fl = 4'b1111;
    end else if (m_err) begin
      en = 5'b00000; to = 1'b1;
    end else if (bus.dmem_req && !bus.dmem_ready) begin
      en = 5'b00001; fl = 4'b0001;
    end else if (bus.exmem_branch && bus.exmem_zero) begin
      fl = 4'b1110; pc = 1'b1;
    end else if (hazard_hit()) begin
      en = 5'b00111; fl = 4'b0100;
    end
    return {en, fl, pc, to};
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.en_pc, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb,
            bus.flush_ifid, bus.flush_idex, bus.flush_exmem, bus.flush_memwb,
            bus.pc_sel_branch, bus.mem_timeout};
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return CW'(v);
`else
    return CW'(v & 0);
`endif
  endfunction

  task automatic model_adv();
    if (rst) begin
      m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0; m_wtot = 0;
    end else if (!m_err) begin
      if (bus.dmem_req && !bus.dmem_ready) begin
        m_waited++;
        if (m_wtot < CMAX) m_wtot++;
        if (m_waited == MAX_WAIT) m_err = 1;
      end else begin
        m_waited = 0;
        if (bus.exmem_branch && bus.exmem_zero) begin
          if (m_flush < CMAX) m_flush++;
        end else if (hazard_hit()) begin
          if (m_stall < CMAX) m_stall++;
        end
      end
    end
  endtask

  task automatic idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.idex_mem_read = 1'b0; bus.idex_rt = '0;
    bus.exmem_branch = 1'b0; bus.exmem_zero = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    idle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = model_out();
      n_cmp++;
      if (dut_out() !== exp) begin
        n_fail++; $display("FAIL reset_outputs cyc%0d: got %b want %b", i, dut_out(), exp);
      end
      model_adv();
      next_edge();
    end
    rst = 1'b0;
    @(negedge clk);
    exp = model_out();
    n_cmp++;
    if (dut_out() !== exp) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", dut_out(), exp);
    end
    n_cmp++;
    if ({bus.stall_cnt, bus.flush_cnt, bus.wait_cnt_total} !== {3*CW{1'b0}}) begin
      n_fail++; $display("FAIL reset_counters: got %h want 0", {bus.stall_cnt, bus.flush_cnt, bus.wait_cnt_total});
    end
    model_adv();
    next_edge();
  endtask

  task automatic test_load_use();
    // {mem_read, idex_rt, id_rs, id_rt}
    logic [15:0] tbl [6];
    logic [10:0] exp;
    tbl = '{{1'b1, 5'd5, 5'd5, 5'd0}, {1'b0, 5'd5, 5'd5, 5'd5}, {1'b1, 5'd0, 5'd0, 5'd0},
            {1'b1, 5'd7, 5'd3, 5'd7}, {1'b1, 5'd9, 5'd8, 5'd10}, {1'b1, 5'd31, 5'd31, 5'd31}};
    idle();
    for (int i = 0; i < 6; i++) begin
      {bus.idex_mem_read, bus.idex_rt, bus.id_rs, bus.id_rt} = tbl[i];
      @(negedge clk);
      exp = model_out();
      n_cmp++;
      if (dut_out() !== exp) begin
        n_fail++; $display("FAIL load_use row%0d: got %b want %b", i, dut_out(), exp);
      end
      model_adv();
      next_edge();
    end
    idle();
  endtask

  task automatic test_branch();
    logic [10:0] exp;
    logic [1:0]  tbl [4];
    tbl = '{2'b11, 2'b10, 2'b01, 2'b00};
    idle();
    for (int i = 0; i < 4; i++) begin
      {bus.exmem_branch, bus.exmem_zero} = tbl[i];
      @(negedge clk);
      exp = model_out();
      n_cmp++;
      if (dut_out() !== exp) begin
        n_fail++; $display("FAIL branch row%0d: got %b want %b", i, dut_out(), exp);
      end
      model_adv();
      next_edge();
    end
  endtask

  task automatic test_mem_wait();
    logic [10:0] exp;
    int          frz;
    int          base;
    idle();
    frz  = 0;
    base = m_wtot;
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.dmem_ready = (i >= 4);
      if (i == 5) bus.dmem_req = 1'b0;
      @(negedge clk);
      exp = model_out();
      n_cmp++;
      if (dut_out() !== exp) begin
        n_fail++; $display("FAIL mem_wait cyc%0d: got %b want %b", i, dut_out(), exp);
      end
      if (bus.flush_memwb && !bus.en_exmem) frz++;
      model_adv();
      next_edge();
    end
    n_cmp++;
    if (frz != 4) begin
      n_fail++; $display("FAIL mem_wait_freeze_cycles: got %0d want 4", frz);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.wait_cnt_total !== exp_cnt(m_wtot) || m_wtot - base != 4) begin
      n_fail++; $display("FAIL mem_wait_total: got %0d want %0d", bus.wait_cnt_total, exp_cnt(m_wtot));
    end
    next_edge();
  endtask

  task automatic test_boundary();
    logic [10:0] exp;
    // Ready arrives on wait cycle MAX_WAIT-1, then on cycle MAX_WAIT: neither may trap.
    for (int r = MAX_WAIT - 1; r <= MAX_WAIT; r++) begin
      idle();
      bus.dmem_req = 1'b1;
      for (int i = 1; i <= r + 1; i++) begin
        bus.dmem_ready = (i == r);
        if (i == r + 1) bus.dmem_req = 1'b0;
        @(negedge clk);
        exp = model_out();
        n_cmp++;
        if (dut_out() !== exp) begin
          n_fail++; $display("FAIL boundary r%0d cyc%0d: got %b want %b", r, i, dut_out(), exp);
        end
        model_adv();
        next_edge();
      end
      @(negedge clk);
      n_cmp++;
      if (bus.mem_timeout !== 1'b0) begin
        n_fail++; $display("FAIL boundary_no_timeout r%0d: got %b want 0", r, bus.mem_timeout);
      end
      next_edge();
    end
    idle();
  endtask

  task automatic test_priority();
    logic [10:0] exp;
    idle();
    bus.idex_mem_read = 1'b1; bus.idex_rt = 5'd4; bus.id_rs = 5'd4;
    bus.exmem_branch  = 1'b1; bus.exmem_zero = 1'b1; bus.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.dmem_ready = (i == 2);
      @(negedge clk);
      exp = model_out();
      n_cmp++;
      if (dut_out() !== exp) begin
        n_fail++; $display("FAIL priority cyc%0d: got %b want %b", i, dut_out(), exp);
      end
      if (i == 2) begin
        n_cmp++;
        if ({bus.pc_sel_branch, bus.en_pc, bus.flush_idex} !== 3'b111) begin
          n_fail++; $display("FAIL priority_branch_on_ready: got %b want 111",
                             {bus.pc_sel_branch, bus.en_pc, bus.flush_idex});
        end
      end
      model_adv();
      next_edge();
    end
    idle();
  endtask

  task automatic test_random();
    logic [10:0] exp;
    for (int i = 0; i < 3000; i++) begin
      rst               = ($urandom_range(0, 199) == 0);
      bus.id_rs         = 5'($urandom_range(0, 3));
      bus.id_rt         = 5'($urandom_range(0, 3));
      bus.idex_rt       = 5'($urandom_range(0, 3));
      bus.idex_mem_read = $urandom_range(0, 1);
      bus.exmem_branch  = ($urandom_range(0, 3) == 0);
      bus.exmem_zero    = $urandom_range(0, 1);
      bus.dmem_req      = ($urandom_range(0, 2) == 0);
      bus.dmem_ready    = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      exp = model_out();
      n_cmp++;
      if (dut_out() !== exp) begin
        n_fail++; $display("FAIL random cyc%0d: got %b want %b", i, dut_out(), exp);
      end
      n_cmp++;
      if ({bus.stall_cnt, bus.flush_cnt, bus.wait_cnt_total} !==
          {exp_cnt(m_stall), exp_cnt(m_flush), exp_cnt(m_wtot)}) begin
        n_fail++; $display("FAIL random_counters cyc%0d: got %h want %h", i,
                           {bus.stall_cnt, bus.flush_cnt, bus.wait_cnt_total},
                           {exp_cnt(m_stall), exp_cnt(m_flush), exp_cnt(m_wtot)});
      end
      model_adv();
      next_edge();
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_timeout();
    logic [10:0] exp;
    idle();
    bus.dmem_req = 1'b1;
    for (int i = 1; i <= MAX_WAIT + 6; i++) begin
      bus.dmem_ready = (i > MAX_WAIT + 2);
      @(negedge clk);
      exp = model_out();
      n_cmp++;
      if (dut_out() !== exp) begin
        n_fail++; $display("FAIL timeout cyc%0d: got %b want %b", i, dut_out(), exp);
      end
      if (i == MAX_WAIT + 1) begin
        n_cmp++;
        if ({bus.mem_timeout, bus.en_pc, bus.en_memwb} !== 3'b100) begin
          n_fail++; $display("FAIL timeout_trap: got %b want 100", {bus.mem_timeout, bus.en_pc, bus.en_memwb});
        end
      end
      model_adv();
      next_edge();
    end
    rst = 1'b1;
    @(negedge clk);
    model_adv();
    next_edge();
    rst = 1'b0;
    idle();
    @(negedge clk);
    exp = model_out();
    n_cmp++;
    if (dut_out() !== exp || bus.mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_recover: got %b want %b", dut_out(), exp);
    end
    model_adv();
    next_edge();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_boundary();
    test_priority();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
